// File: rtl/bank_power_sequencer.sv
// bank_power_sequencer
//   Per-bank power sequencer for the eDRAM macro. Each bank walks OFF -> WAKING -> ACTIVE ->
//   STANDBY -> OFF under programmable timeouts and drives the array power switch (pwr_en) and
//   reverse-body-bias (rbb_en) enables. An inrush limiter admits at most MAX_WAKE banks into
//   WAKING at once, lowest bank index first.
//   Optional feature: define BANK_PWR_FORCE_OFF_EN to add the force_off input, which sends an
//   idle ACTIVE/STANDBY bank straight to OFF. Without it, banks reach OFF only by sleep timeout.
module bank_power_sequencer #(
  parameter int NUM_BANKS = 16,
  parameter int WAKE_CYC  = 50,
  parameter int IDLE_CYC  = 150,
  parameter int SLEEP_CYC = 1000,
  parameter int MAX_WAKE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] req,
  input  logic [NUM_BANKS-1:0] busy,
`ifdef BANK_PWR_FORCE_OFF_EN
  input  logic [NUM_BANKS-1:0] force_off,
`endif
  output logic [NUM_BANKS-1:0] bank_ready,
  output logic [NUM_BANKS-1:0] pwr_en,
  output logic [NUM_BANKS-1:0] rbb_en,
  output logic [NUM_BANKS-1:0] waking,
  output logic [6:0]           wake_cnt
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int MAX_WI  = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam int MAX_CYC = (MAX_WI > SLEEP_CYC) ? MAX_WI : SLEEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Sparse 3-bit encoding so that corrupted state values are detectable and
  // can be steered back to OFF.
  localparam logic [2:0] ST_OFF     = 3'b000;
  localparam logic [2:0] ST_WAKING  = 3'b001;
  localparam logic [2:0] ST_ACTIVE  = 3'b010;
  localparam logic [2:0] ST_STANDBY = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_CYC - 1);
  localparam logic [6:0]       MAX_WAKE_N = 7'(MAX_WAKE);

  // ---------------------------------------------------------------------------
  // Parameter range checks (elaboration time)
  // ---------------------------------------------------------------------------
  if (NUM_BANKS < 1 || NUM_BANKS > 64) begin : g_chk_num_banks
    $error("bank_power_sequencer: NUM_BANKS must be in 1..64");
  end
  if (WAKE_CYC < 1) begin : g_chk_wake_cyc
    $error("bank_power_sequencer: WAKE_CYC must be >= 1");
  end
  if (IDLE_CYC < 1) begin : g_chk_idle_cyc
    $error("bank_power_sequencer: IDLE_CYC must be >= 1");
  end
  if (SLEEP_CYC < 1) begin : g_chk_sleep_cyc
    $error("bank_power_sequencer: SLEEP_CYC must be >= 1");
  end
  if (MAX_WAKE < 1 || MAX_WAKE > NUM_BANKS) begin : g_chk_max_wake
    $error("bank_power_sequencer: MAX_WAKE must be in 1..NUM_BANKS");
  end

  // ---------------------------------------------------------------------------
  // Per-bank state
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q [NUM_BANKS];
  logic [2:0]       state_d [NUM_BANKS];
  logic [CNT_W-1:0] cnt_q   [NUM_BANKS];
  logic [CNT_W-1:0] cnt_d   [NUM_BANKS];

  logic [NUM_BANKS-1:0] grant;       // OFF bank admitted into WAKING this cycle
  logic [NUM_BANKS-1:0] activity;    // bank is wanted: request or access in flight
  logic [NUM_BANKS-1:0] force_idle;  // forced shutdown request not overridden by req/busy
  logic [6:0]           wake_cnt_d;

  assign activity = req | busy;

`ifdef BANK_PWR_FORCE_OFF_EN
  assign force_idle = force_off & ~req & ~busy;
`else
  assign force_idle = '0;
`endif

  // Inrush limiter: hand the free wake slots to the lowest-index requesting OFF banks.
  always_comb begin
    logic [6:0] slots_left;
    grant = '0;
    // NOTE: slots_left is a running tally inside one combinational pass, so it is
    // updated with blocking assignments; registered state below only ever uses <=.
    slots_left = MAX_WAKE_N - wake_cnt;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (req[i] && (state_q[i] == ST_OFF) && (slots_left != 7'd0)) begin
        grant[i]   = 1'b1;
        slots_left = slots_left - 7'd1;
      end
    end
  end

  // Next-state and counter update for every bank.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      // NOTE: every path starts from hold-current defaults, so no latch can be inferred.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          cnt_d[i] = CNT_ZERO;
          if (grant[i]) begin
            state_d[i] = ST_WAKING;
          end
        end

        // A wake always runs to completion, even if req drops part-way.
        ST_WAKING: begin
          if (cnt_q[i] == WAKE_LAST) begin
            state_d[i] = ST_ACTIVE;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end

        // Idle timer restarts on any activity; activity on the final idle cycle
        // cancels the drop into STANDBY.
        ST_ACTIVE: begin
          if (activity[i]) begin
            cnt_d[i] = CNT_ZERO;
          end else if (force_idle[i]) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == IDLE_LAST) begin
            state_d[i] = ST_STANDBY;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end

        // Retention wake needs no inrush slot; a request beats the sleep timeout.
        ST_STANDBY: begin
          if (req[i]) begin
            state_d[i] = ST_ACTIVE;
            cnt_d[i]   = CNT_ZERO;
          end else if (force_idle[i]) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == SLEEP_LAST) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = CNT_ZERO;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end

        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Number of banks that will be in WAKING after this edge.
  always_comb begin
    wake_cnt_d = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (state_d[i] == ST_WAKING) begin
        wake_cnt_d = wake_cnt_d + 7'd1;
      end
    end
  end

  // State, counters and the wake occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these per-bank arrays are ordinary flops, not RAM, so they take the
      // async reset like any other register.
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= CNT_ZERO;
      end
      wake_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      wake_cnt <= wake_cnt_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    bank_ready = '0;
    pwr_en     = '0;
    rbb_en     = '0;
    waking     = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_ready[i] = (state_q[i] == ST_ACTIVE);
      pwr_en[i]     = (state_q[i] != ST_OFF);
      rbb_en[i]     = (state_q[i] == ST_STANDBY);
      waking[i]     = (state_q[i] == ST_WAKING);
    end
  end

endmodule

// File: tb/tb_bank_power_sequencer.sv
// tb_bank_power_sequencer
//   Directed scenarios plus randomized traffic for bank_power_sequencer. A timestamp-based
//   reference model (mode + time of last timer restart per bank) predicts every output each cycle.
module tb_bank_power_sequencer;

  localparam int NUM_BANKS = 16;
  localparam int WAKE_CYC  = 50;
  localparam int IDLE_CYC  = 150;
  localparam int SLEEP_CYC = 1000;
  localparam int MAX_WAKE  = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_BANKS-1:0] req;
  logic [NUM_BANKS-1:0] busy;
`ifdef BANK_PWR_FORCE_OFF_EN
  logic [NUM_BANKS-1:0] force_off;
`endif
  logic [NUM_BANKS-1:0] bank_ready;
  logic [NUM_BANKS-1:0] pwr_en;
  logic [NUM_BANKS-1:0] rbb_en;
  logic [NUM_BANKS-1:0] waking;
  logic [6:0]           wake_cnt;

  int tests_run;
  int tests_failed;

  bank_power_sequencer #(
    .NUM_BANKS (NUM_BANKS),
    .WAKE_CYC  (WAKE_CYC),
    .IDLE_CYC  (IDLE_CYC),
    .SLEEP_CYC (SLEEP_CYC),
    .MAX_WAKE  (MAX_WAKE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy),
`ifdef BANK_PWR_FORCE_OFF_EN
    .force_off  (force_off),
`endif
    .bank_ready (bank_ready),
    .pwr_en     (pwr_en),
    .rbb_en     (rbb_en),
    .waking     (waking),
    .wake_cnt   (wake_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: each bank has a mode and the edge at which its current
  // timer (wake, idle or sleep) last restarted.
  // ---------------------------------------------------------------------------
  typedef enum int {M_OFF, M_WAKING, M_ACTIVE, M_STANDBY} mode_t;

  mode_t  m_mode  [NUM_BANKS];
  longint m_since [NUM_BANKS];
  longint edge_no;

  function automatic void model_reset();
    for (int i = 0; i < NUM_BANKS; i++) begin
      m_mode[i]  = M_OFF;
      m_since[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int   slots;
    logic fidle;
    edge_no++;
    if (rst) begin
      model_reset();
      return;
    end
    slots = MAX_WAKE;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (m_mode[i] == M_WAKING) slots--;
    end
    for (int i = 0; i < NUM_BANKS; i++) begin
      fidle = 1'b0;
`ifdef BANK_PWR_FORCE_OFF_EN
      fidle = force_off[i] && !req[i] && !busy[i];
`endif
      case (m_mode[i])
        M_OFF: begin
          if (req[i] && slots > 0) begin
            slots--;
            m_mode[i]  = M_WAKING;
            m_since[i] = edge_no;
          end
        end
        M_WAKING: begin
          if (edge_no - m_since[i] >= WAKE_CYC) begin
            m_mode[i]  = M_ACTIVE;
            m_since[i] = edge_no;
          end
        end
        M_ACTIVE: begin
          if (req[i] || busy[i]) begin
            m_since[i] = edge_no;
          end else if (fidle) begin
            m_mode[i] = M_OFF;
          end else if (edge_no - m_since[i] >= IDLE_CYC) begin
            m_mode[i]  = M_STANDBY;
            m_since[i] = edge_no;
          end
        end
        M_STANDBY: begin
          if (req[i]) begin
            m_mode[i]  = M_ACTIVE;
            m_since[i] = edge_no;
          end else if (fidle) begin
            m_mode[i] = M_OFF;
          end else if (edge_no - m_since[i] >= SLEEP_CYC) begin
            m_mode[i] = M_OFF;
          end
        end
        default: m_mode[i] = M_OFF;
      endcase
    end
  endfunction

  function automatic logic [NUM_BANKS-1:0] mask_of(input mode_t m);
    logic [NUM_BANKS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BANKS; i++) r[i] = (m_mode[i] == m);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [NUM_BANKS-1:0] e_ready, e_pwr, e_rbb, e_wake;
    e_ready = mask_of(M_ACTIVE);
    e_pwr   = ~mask_of(M_OFF);
    e_rbb   = mask_of(M_STANDBY);
    e_wake  = mask_of(M_WAKING);
    check("bank_ready", 64'(bank_ready), 64'(e_ready));
    check("pwr_en",     64'(pwr_en),     64'(e_pwr));
    check("rbb_en",     64'(rbb_en),     64'(e_rbb));
    check("waking",     64'(waking),     64'(e_wake));
    check("wake_cnt",   64'(wake_cnt),   64'($countones(e_wake)));
    check("wake_cap",   64'(wake_cnt <= 7'(MAX_WAKE)), 64'd1);
  endtask

  // One clock edge: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = '0;
    busy = '0;
`ifdef BANK_PWR_FORCE_OFF_EN
    force_off = '0;
`endif
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_pwr_en",   64'(pwr_en),   64'd0);
    check("rst_wake_cnt", 64'(wake_cnt), 64'd0);
  endtask

  int dens_tab [8] = '{0, 400, 30, 3, 0, 100, 8, 0};

  initial begin
    int dens;
    tests_run    = 0;
    tests_failed = 0;
    edge_no      = 0;
    rst          = 1'b1;
    req          = '0;
    busy         = '0;
`ifdef BANK_PWR_FORCE_OFF_EN
    force_off    = '0;
`endif
    model_reset();

    // T1: single bank wake latency.
    apply_reset();
    cycle();                                             // edge 1
    check("t1_pwr0_e1", 64'(pwr_en[0]), 64'd0);
    req[0] = 1'b1;
    cycle();                                             // edge 2
    check("t1_pwr0_e2",   64'(pwr_en[0]), 64'd1);
    check("t1_waking0",   64'(waking[0]), 64'd1);
    for (int e = 3; e <= 52; e++) begin
      cycle();
      if (e == 51) check("t1_ready0_e51", 64'(bank_ready[0]), 64'd0);
    end
    check("t1_ready0_e52", 64'(bank_ready[0]), 64'd1);
    check("t1_rbb",        64'(rbb_en),        64'd0);
    req = '0;

    // T2: all banks request, two wake slots.
    apply_reset();
    busy = '1;
    cycle();                                             // edge 1
    req = '1;
    for (int e = 2; e <= 409; e++) begin
      cycle();
      if (e == 2)   check("t2_first_pair",  64'(waking),     64'h0003);
      if (e == 52)  check("t2_slot_lag",    64'(waking),     64'h0000);
      if (e == 53)  check("t2_second_pair", 64'(waking),     64'h000C);
      if (e == 408) check("t2_ready_e408",  64'(bank_ready), 64'h3FFF);
      req = req & ~bank_ready;
    end
    check("t2_all_ready", 64'(bank_ready), 64'hFFFF);

    // T3: bank 3 idles into STANDBY, then retention wake.
    req  = '0;
    busy = 16'hFFF7;
    repeat (149) cycle();
    check("t3_rbb3_149",   64'(rbb_en[3]),     64'd0);
    cycle();
    check("t3_rbb3_150",   64'(rbb_en[3]),     64'd1);
    check("t3_ready3_off", 64'(bank_ready[3]), 64'd0);
    req[3] = 1'b1;
    cycle();
    check("t3_ready3_ret", 64'(bank_ready[3]), 64'd1);
    check("t3_no_waking3", 64'(waking[3]),     64'd0);
    req = '0;

    // T5a: busy pulse on the final idle cycle cancels STANDBY.
    repeat (149) cycle();
    busy[3] = 1'b1;
    cycle();
    check("t5_busy_cancel", 64'(bank_ready[3]), 64'd1);
    busy[3] = 1'b0;
    repeat (149) cycle();
    check("t5_ready3_149", 64'(bank_ready[3]), 64'd1);
    cycle();
    check("t5_rbb3_150",   64'(rbb_en[3]),     64'd1);

    // T4: STANDBY sleep timeout, then request on the last sleep cycle.
    repeat (999) cycle();
    check("t4_pwr3_999", 64'(pwr_en[3]), 64'd1);
    cycle();
    check("t4_pwr3_off", 64'(pwr_en[3]), 64'd0);
    check("t4_rbb3_off", 64'(rbb_en[3]), 64'd0);
    req[3] = 1'b1;
    cycle();
    check("t4_rewake3", 64'(waking[3]), 64'd1);
    repeat (50) cycle();
    check("t4_ready3", 64'(bank_ready[3]), 64'd1);
    req = '0;
    repeat (150) cycle();
    check("t4_stby3", 64'(rbb_en[3]), 64'd1);
    repeat (999) cycle();
    req[3] = 1'b1;
    cycle();
    check("t4_req_wins_rdy", 64'(bank_ready[3]), 64'd1);
    check("t4_req_wins_pwr", 64'(pwr_en[3]),     64'd1);
    req = '0;

    // T5b: asynchronous reset in the middle of a wake.
    apply_reset();
    req = '1;
    repeat (10) cycle();
    check("t5_pre_rst_waking", 64'(waking), 64'h0003);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ready",    64'(bank_ready), 64'd0);
    check("t5_rst_pwr",      64'(pwr_en),     64'd0);
    check("t5_rst_rbb",      64'(rbb_en),     64'd0);
    check("t5_rst_waking",   64'(waking),     64'd0);
    check("t5_rst_wake_cnt", 64'(wake_cnt),   64'd0);
    model_reset();
    req = '0;
    repeat (2) cycle();
    rst = 1'b0;

`ifdef BANK_PWR_FORCE_OFF_EN
    // T6: force_off on idle ACTIVE bank 2, overridden by busy.
    apply_reset();
    cycle();
    req[2] = 1'b1;
    repeat (51) cycle();
    check("t6_ready2", 64'(bank_ready[2]), 64'd1);
    req = '0;
    busy[2]      = 1'b1;
    force_off[2] = 1'b1;
    cycle();
    check("t6_busy_override", 64'(bank_ready[2]), 64'd1);
    busy[2] = 1'b0;
    cycle();
    check("t6_forced_off", 64'(pwr_en[2]), 64'd0);
    force_off = '0;
`endif

    // Randomized traffic: phases of differing request density, quiet phases let
    // banks fall through STANDBY to OFF.
    apply_reset();
    for (int ph = 0; ph < 8; ph++) begin
      dens = dens_tab[ph];
      for (int c = 0; c < 2000; c++) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (bank_ready[i]) req[i] = 1'b0;
          else if (dens != 0 && $urandom_range(dens - 1, 0) == 0) req[i] = 1'b1;
          if ($urandom_range(199, 0) == 0) req[i] = 1'b0;
          busy[i] = (dens != 0) && ($urandom_range(dens - 1, 0) == 0);
`ifdef BANK_PWR_FORCE_OFF_EN
          force_off[i] = ($urandom_range(99, 0) == 0);
`endif
        end
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
